spu_reg_fetch_fwd: RTL and testbench
====================================

// Module: spu_reg_fetch_fwd
// PURPOSE
//  RF/FWD stage of the dual-issue SPU. Sits directly upstream of the even and odd execution pipes.
//  Holds the 128x128 register file, which has two write ports fed by the even and odd WB outputs.
//  Reads all source operands for an issued pair and resolves RAW bypass from both pipes' fw stages.
//  Registers operands plus pass-through control into the pipes. Latency: 1 cycle.
// PARAMETERS
//  DATA_W  128  register/operand width
//  ADDR_W  7    register address width (2**ADDR_W registers)
//  FW_N    7    forwarding stages per pipe; index 0 unused, 1..FW_N-1 valid
//  CTRL_W  48   opaque per-slot control bundle (op, format, unit, rt_addr, imm, reg_write, pc, first)
// PORTS
//  clk            in   1             clock
//  reset          in   1             synchronous, active-high
//  stall          in   1             hold stage outputs (RAW stall from pipes)
//  flush          in   1             branch taken; kill stage contents
//  ev_in_valid    in   1             even slot valid from decode
//  ev_ra_addr, ev_rb_addr, ev_rc_addr   in  ADDR_W  even source regs
//  ev_ctrl_in     in   CTRL_W        even control
//  od_in_valid    in   1             odd slot valid from decode
//  od_ra_addr, od_rb_addr, od_rt_addr   in  ADDR_W  odd sources (rt = store data)
//  od_ctrl_in     in   CTRL_W        odd control
//  ev_wb_data/od_wb_data    in  DATA_W  pipe WB value
//  ev_wb_addr/od_wb_addr    in  ADDR_W  WB destination
//  ev_wb_en/od_wb_en        in  1       WB write enable
//  ev_fw_data/od_fw_data    in  [FW_N][DATA_W]  in-flight results
//  ev_fw_addr/od_fw_addr    in  [FW_N][ADDR_W]  in-flight destinations
//  ev_fw_write/od_fw_write  in  [FW_N]          in-flight write flags
//  ev_valid, od_valid       out 1       slot valid to pipe
//  ev_ra, ev_rb, ev_rc      out DATA_W  even operands
//  od_ra, od_rb, od_rt_st   out DATA_W  odd operands
//  ev_ctrl, od_ctrl         out CTRL_W  registered control
// BEHAVIOUR
//  Reset: all registers and all outputs = 0.
//  Regfile write at posedge when wb_en=1. Same address on both ports: odd data written.
//  Operand resolve, per source address, highest priority first:
//    fw stage 1..FW_N-1, lowest index first. At equal index, odd matches before even.
//    Then WB write-through; both ports match: odd wins.
//    Then regfile.
//  Entries with write=0 never match. Index 0 ignored.
//  Advance (stall=0, flush=0): capture in_valid, ctrl, source addresses; register resolved operands.
//  Invalid slot (in_valid=0): valid, ctrl and operands of that slot all 0.
//  Stall (flush=0): valid, ctrl and held addresses unchanged. Operands re-resolved every cycle from held addresses.
//  This picks up producers that reach fw/WB during the stall, so released operands are never stale.
//  Flush: valid=0, ctrl=0, operands=0 next cycle. Flush wins over stall.
//  Reset mid-stall or mid-flush: reset wins. Regfile returns to all-zero.
//  No address is special; reg 0 reads and writes normally.
// CONFIGURATION
//  SPU_RF_FWD_BYPASS_EN defined: full fw-stage bypass network as above.
//  Undefined: fw inputs ignored; operands from WB write-through, then regfile only.
//  Without the macro the pipes must stall until the producer reaches WB.
// TESTING
//  Reset, then read r5/r6/r7 even -> all operands 0, ev_valid=0 until first valid issue.
//  WB odd r5=0xA5.., next cycle issue ev_ra=r5 -> ev_ra=0xA5..; same-cycle WB+issue -> write-through value.
//  od_fw_addr[4]=r9 val=1, ev_fw_addr[2]=r9 val=2, issue od_ra=r9 -> od_ra=2 (lowest index); with macro off -> regfile value.
//  Stall 3 cycles holding ev_rb=r3 while ev_wb writes r3=0x77 -> ev_rb becomes 0x77, ctrl/valid unchanged.
//  Assert flush and stall together with valid pair -> next cycle ev_valid=od_valid=0, ctrl=0.
//  Both WB ports write r12 (ev=1, od=2) -> later read r12 returns 2.

Source files
------------

// File: rtl/spu_reg_fetch_fwd_if.sv
// Issue, writeback, forwarding and operand bundle of the SPU RF/FWD stage.
// master = decode/pipe side, slave = the RF/FWD stage.
interface spu_reg_fetch_fwd_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 7,
    parameter int FW_N   = 7,
    parameter int CTRL_W = 48
);
    logic                           ev_in_valid;
    logic [ADDR_W-1:0]              ev_ra_addr;
    logic [ADDR_W-1:0]              ev_rb_addr;
    logic [ADDR_W-1:0]              ev_rc_addr;
    logic [CTRL_W-1:0]              ev_ctrl_in;
    logic                           od_in_valid;
    logic [ADDR_W-1:0]              od_ra_addr;
    logic [ADDR_W-1:0]              od_rb_addr;
    logic [ADDR_W-1:0]              od_rt_addr;
    logic [CTRL_W-1:0]              od_ctrl_in;

    logic [DATA_W-1:0]              ev_wb_data;
    logic [ADDR_W-1:0]              ev_wb_addr;
    logic                           ev_wb_en;
    logic [DATA_W-1:0]              od_wb_data;
    logic [ADDR_W-1:0]              od_wb_addr;
    logic                           od_wb_en;

    logic [FW_N-1:0][DATA_W-1:0]    ev_fw_data;
    logic [FW_N-1:0][ADDR_W-1:0]    ev_fw_addr;
    logic [FW_N-1:0]                ev_fw_write;
    logic [FW_N-1:0][DATA_W-1:0]    od_fw_data;
    logic [FW_N-1:0][ADDR_W-1:0]    od_fw_addr;
    logic [FW_N-1:0]                od_fw_write;

    logic                           ev_valid;
    logic [DATA_W-1:0]              ev_ra;
    logic [DATA_W-1:0]              ev_rb;
    logic [DATA_W-1:0]              ev_rc;
    logic [CTRL_W-1:0]              ev_ctrl;
    logic                           od_valid;
    logic [DATA_W-1:0]              od_ra;
    logic [DATA_W-1:0]              od_rb;
    logic [DATA_W-1:0]              od_rt_st;
    logic [CTRL_W-1:0]              od_ctrl;

    modport master (
        output ev_in_valid, ev_ra_addr, ev_rb_addr, ev_rc_addr, ev_ctrl_in,
        output od_in_valid, od_ra_addr, od_rb_addr, od_rt_addr, od_ctrl_in,
        output ev_wb_data, ev_wb_addr, ev_wb_en,
        output od_wb_data, od_wb_addr, od_wb_en,
        output ev_fw_data, ev_fw_addr, ev_fw_write,
        output od_fw_data, od_fw_addr, od_fw_write,
        input  ev_valid, ev_ra, ev_rb, ev_rc, ev_ctrl,
        input  od_valid, od_ra, od_rb, od_rt_st, od_ctrl
    );

    modport slave (
        input  ev_in_valid, ev_ra_addr, ev_rb_addr, ev_rc_addr, ev_ctrl_in,
        input  od_in_valid, od_ra_addr, od_rb_addr, od_rt_addr, od_ctrl_in,
        input  ev_wb_data, ev_wb_addr, ev_wb_en,
        input  od_wb_data, od_wb_addr, od_wb_en,
        input  ev_fw_data, ev_fw_addr, ev_fw_write,
        input  od_fw_data, od_fw_addr, od_fw_write,
        output ev_valid, ev_ra, ev_rb, ev_rc, ev_ctrl,
        output od_valid, od_ra, od_rb, od_rt_st, od_ctrl
    );
endinterface

// File: rtl/spu_reg_fetch_fwd.sv
// SPU RF/FWD stage: 2W regfile, dual-slot operand read with fw/WB bypass.
// SPU_RF_FWD_BYPASS_EN enables the fw-stage bypass network.
module spu_reg_fetch_fwd #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 7,
    parameter int FW_N   = 7,
    parameter int CTRL_W = 48
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall_i,
    input  logic                 flush_i,
    spu_reg_fetch_fwd_if.slave   rf_if
);
    localparam int NREG = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] dat_t;
    typedef logic [ADDR_W-1:0] adr_t;

    dat_t              rf_q [NREG];

    logic              ev_valid_q, ev_valid_d;
    logic              od_valid_q, od_valid_d;
    logic [CTRL_W-1:0] ev_ctrl_q, ev_ctrl_d;
    logic [CTRL_W-1:0] od_ctrl_q, od_ctrl_d;
    adr_t              src_q [6];
    adr_t              src_d [6];
    dat_t              opr_q [6];
    dat_t              opr_d [6];
    adr_t              src_in [6];
    adr_t              src_sel [6];
    logic              ev_en, od_en;

    assign src_in[0] = rf_if.ev_ra_addr;
    assign src_in[1] = rf_if.ev_rb_addr;
    assign src_in[2] = rf_if.ev_rc_addr;
    assign src_in[3] = rf_if.od_ra_addr;
    assign src_in[4] = rf_if.od_rb_addr;
    assign src_in[5] = rf_if.od_rt_addr;

    // Later assignments win: regfile < even WB < odd WB < fw (high idx .. idx 1).
    function automatic dat_t resolve(input adr_t a);
        dat_t v;
        v = rf_q[a];
        if (rf_if.ev_wb_en && rf_if.ev_wb_addr == a) v = rf_if.ev_wb_data;
        if (rf_if.od_wb_en && rf_if.od_wb_addr == a) v = rf_if.od_wb_data;
`ifdef SPU_RF_FWD_BYPASS_EN
        for (int i = FW_N - 1; i >= 1; i--) begin
            if (rf_if.ev_fw_write[i] && rf_if.ev_fw_addr[i] == a)
                v = rf_if.ev_fw_data[i];
            if (rf_if.od_fw_write[i] && rf_if.od_fw_addr[i] == a)
                v = rf_if.od_fw_data[i];
        end
`endif
        return v;
    endfunction

`ifndef SPU_RF_FWD_BYPASS_EN
    logic unused_fw;
    assign unused_fw = ^{rf_if.ev_fw_data, rf_if.ev_fw_addr, rf_if.ev_fw_write,
                         rf_if.od_fw_data, rf_if.od_fw_addr, rf_if.od_fw_write};
`endif

    always_comb begin
        ev_en      = stall_i ? ev_valid_q : rf_if.ev_in_valid;
        od_en      = stall_i ? od_valid_q : rf_if.od_in_valid;
        ev_valid_d = ev_valid_q;
        od_valid_d = od_valid_q;
        ev_ctrl_d  = ev_ctrl_q;
        od_ctrl_d  = od_ctrl_q;
        for (int k = 0; k < 6; k++) begin
            src_sel[k] = stall_i ? src_q[k] : src_in[k];
            src_d[k]   = src_q[k];
            opr_d[k]   = '0;
        end
        if (!stall_i) begin
            ev_valid_d = rf_if.ev_in_valid;
            od_valid_d = rf_if.od_in_valid;
            ev_ctrl_d  = rf_if.ev_in_valid ? rf_if.ev_ctrl_in : '0;
            od_ctrl_d  = rf_if.od_in_valid ? rf_if.od_ctrl_in : '0;
            for (int k = 0; k < 6; k++) src_d[k] = src_in[k];
        end
        // Re-resolving while stalled lets late producers reach held operands.
        for (int k = 0; k < 3; k++) begin
            if (ev_en) opr_d[k] = resolve(src_sel[k]);
            if (od_en) opr_d[k+3] = resolve(src_sel[k+3]);
        end
        if (flush_i) begin
            ev_valid_d = 1'b0;
            od_valid_d = 1'b0;
            ev_ctrl_d  = '0;
            od_ctrl_d  = '0;
            for (int k = 0; k < 6; k++) opr_d[k] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ev_valid_q <= 1'b0;
            od_valid_q <= 1'b0;
            ev_ctrl_q  <= '0;
            od_ctrl_q  <= '0;
            for (int k = 0; k < 6; k++) begin
                src_q[k] <= '0;
                opr_q[k] <= '0;
            end
            for (int r = 0; r < NREG; r++) rf_q[r] <= '0;
        end else begin
            ev_valid_q <= ev_valid_d;
            od_valid_q <= od_valid_d;
            ev_ctrl_q  <= ev_ctrl_d;
            od_ctrl_q  <= od_ctrl_d;
            for (int k = 0; k < 6; k++) begin
                src_q[k] <= src_d[k];
                opr_q[k] <= opr_d[k];
            end
            if (rf_if.ev_wb_en) rf_q[rf_if.ev_wb_addr] <= rf_if.ev_wb_data;
            if (rf_if.od_wb_en) rf_q[rf_if.od_wb_addr] <= rf_if.od_wb_data;
        end
    end

    assign rf_if.ev_valid = ev_valid_q;
    assign rf_if.ev_ctrl  = ev_ctrl_q;
    assign rf_if.ev_ra    = opr_q[0];
    assign rf_if.ev_rb    = opr_q[1];
    assign rf_if.ev_rc    = opr_q[2];
    assign rf_if.od_valid = od_valid_q;
    assign rf_if.od_ctrl  = od_ctrl_q;
    assign rf_if.od_ra    = opr_q[3];
    assign rf_if.od_rb    = opr_q[4];
    assign rf_if.od_rt_st = opr_q[5];
endmodule

// File: tb/tb_spu_reg_fetch_fwd.sv
// Directed bench for spu_reg_fetch_fwd; expectations are queued per cycle
// and checked by an independent monitor on the falling edge.
module tb_spu_reg_fetch_fwd;
    logic clk = 1'b0;
    logic reset;
    logic stall;
    logic flush;

    always #5 clk = ~clk;

    spu_reg_fetch_fwd_if bus ();

    spu_reg_fetch_fwd dut (
        .clk     (clk),
        .reset   (reset),
        .stall_i (stall),
        .flush_i (flush),
        .rf_if   (bus)
    );

    typedef struct packed {
        logic         ev_v;
        logic         od_v;
        logic [127:0] e_ra;
        logic [127:0] e_rb;
        logic [127:0] e_rc;
        logic [127:0] o_ra;
        logic [127:0] o_rb;
        logic [127:0] o_rt;
        logic [47:0]  e_ctl;
        logic [47:0]  o_ctl;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    localparam logic [127:0] A5  = {16{8'hA5}};
    localparam logic [127:0] D8  = {16{8'hD8}};
    localparam logic [127:0] N9  = {16{8'h99}};
    localparam logic [127:0] S77 = {16{8'h77}};
    localparam logic [127:0] R0  = {16{8'h33}};

    task automatic cmp(input string n, input logic [127:0] a,
                       input logic [127:0] x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", n, a, x);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t m;
            m = q.pop_front();
            cmp("ev_valid", {127'd0, bus.ev_valid}, {127'd0, m.ev_v});
            cmp("od_valid", {127'd0, bus.od_valid}, {127'd0, m.od_v});
            cmp("ev_ra", bus.ev_ra, m.e_ra);
            cmp("ev_rb", bus.ev_rb, m.e_rb);
            cmp("ev_rc", bus.ev_rc, m.e_rc);
            cmp("od_ra", bus.od_ra, m.o_ra);
            cmp("od_rb", bus.od_rb, m.o_rb);
            cmp("od_rt_st", bus.od_rt_st, m.o_rt);
            cmp("ev_ctrl", {80'd0, bus.ev_ctrl}, {80'd0, m.e_ctl});
            cmp("od_ctrl", {80'd0, bus.od_ctrl}, {80'd0, m.o_ctl});
        end
    end

    task automatic clr();
        stall = 0; flush = 0;
        bus.ev_in_valid = 0; bus.ev_ra_addr = 0; bus.ev_rb_addr = 0;
        bus.ev_rc_addr = 0; bus.ev_ctrl_in = 0;
        bus.od_in_valid = 0; bus.od_ra_addr = 0; bus.od_rb_addr = 0;
        bus.od_rt_addr = 0; bus.od_ctrl_in = 0;
        bus.ev_wb_data = 0; bus.ev_wb_addr = 0; bus.ev_wb_en = 0;
        bus.od_wb_data = 0; bus.od_wb_addr = 0; bus.od_wb_en = 0;
        bus.ev_fw_data = '0; bus.ev_fw_addr = '0; bus.ev_fw_write = '0;
        bus.od_fw_data = '0; bus.od_fw_addr = '0; bus.od_fw_write = '0;
    endtask

    task automatic tick(input exp_t e);
        @(posedge clk);
        #1;
        q.push_back(e);
    endtask

    initial begin
        exp_t e;
        // reset wins over a valid issue
        reset = 1; clr();
        bus.ev_in_valid = 1; bus.ev_ra_addr = 5; bus.ev_ctrl_in = 48'h1;
        e = '0; tick(e);
        // idle after reset
        @(negedge clk); reset = 0; clr();
        e = '0; tick(e);
        // odd WB r5
        @(negedge clk); clr();
        bus.od_wb_en = 1; bus.od_wb_addr = 5; bus.od_wb_data = A5;
        e = '0; tick(e);
        // read r5 from regfile
        @(negedge clk); clr();
        bus.ev_in_valid = 1; bus.ev_ra_addr = 5; bus.ev_ctrl_in = 48'hC2;
        e = '0; e.ev_v = 1; e.e_ra = A5; e.e_ctl = 48'hC2; tick(e);
        // WB write-through on both slots
        @(negedge clk); clr();
        bus.ev_wb_en = 1; bus.ev_wb_addr = 8; bus.ev_wb_data = D8;
        bus.od_wb_en = 1; bus.od_wb_addr = 9; bus.od_wb_data = N9;
        bus.ev_in_valid = 1; bus.ev_ra_addr = 8; bus.ev_ctrl_in = 48'hC2;
        bus.od_in_valid = 1; bus.od_ra_addr = 8; bus.od_rt_addr = 9;
        bus.od_ctrl_in = 48'h0_1;
        e = '0; e.ev_v = 1; e.e_ra = D8; e.e_ctl = 48'hC2;
        e.od_v = 1; e.o_ra = D8; e.o_rt = N9; e.o_ctl = 48'h1; tick(e);
        // fw priority: lowest index, odd before even, write=0 and idx 0 ignored
        @(negedge clk); clr();
        bus.od_fw_addr[4] = 9; bus.od_fw_data[4] = 1; bus.od_fw_write[4] = 1;
        bus.ev_fw_addr[2] = 9; bus.ev_fw_data[2] = 2; bus.ev_fw_write[2] = 1;
        bus.od_fw_addr[3] = 9; bus.od_fw_data[3] = 3; bus.od_fw_write[3] = 0;
        bus.ev_fw_addr[0] = 9; bus.ev_fw_data[0] = 7; bus.ev_fw_write[0] = 1;
        bus.ev_fw_addr[1] = 10; bus.ev_fw_data[1] = 5; bus.ev_fw_write[1] = 1;
        bus.od_fw_addr[1] = 10; bus.od_fw_data[1] = 6; bus.od_fw_write[1] = 1;
        bus.od_in_valid = 1; bus.od_ra_addr = 9; bus.od_rb_addr = 10;
        bus.od_ctrl_in = 48'h2;
        e = '0; e.od_v = 1; e.o_ctl = 48'h2;
`ifdef SPU_RF_FWD_BYPASS_EN
        e.o_ra = 128'd2; e.o_rb = 128'd6;
`else
        e.o_ra = N9; e.o_rb = 128'd0;
`endif
        tick(e);
        // issue ev_rb=r3 (still zero)
        @(negedge clk); clr();
        bus.ev_in_valid = 1; bus.ev_rb_addr = 3; bus.ev_ctrl_in = 48'hC3;
        e = '0; e.ev_v = 1; e.e_ctl = 48'hC3; tick(e);
        // stall 3 cycles, r3 written by even WB during the first
        @(negedge clk); clr(); stall = 1;
        bus.ev_rb_addr = 4; bus.ev_ctrl_in = 48'hBAD;
        bus.ev_wb_en = 1; bus.ev_wb_addr = 3; bus.ev_wb_data = S77;
        e = '0; e.ev_v = 1; e.e_ctl = 48'hC3; e.e_rb = S77; tick(e);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); clr(); stall = 1;
            bus.ev_in_valid = 1; bus.ev_rb_addr = 4; bus.ev_ctrl_in = 48'hBAD;
            tick(e);
        end
        // release: new pair, r3 from regfile
        @(negedge clk); clr();
        bus.ev_in_valid = 1; bus.ev_ra_addr = 3; bus.ev_ctrl_in = 48'hC4;
        bus.od_in_valid = 1; bus.od_ctrl_in = 48'h4;
        e = '0; e.ev_v = 1; e.e_ra = S77; e.e_ctl = 48'hC4;
        e.od_v = 1; e.o_ctl = 48'h4; tick(e);
        // flush wins over stall
        @(negedge clk); clr(); stall = 1; flush = 1;
        bus.ev_in_valid = 1; bus.ev_ra_addr = 3; bus.ev_ctrl_in = 48'hC5;
        bus.od_in_valid = 1; bus.od_ctrl_in = 48'h5;
        e = '0; tick(e);
        // both WB ports write r12: odd wins
        @(negedge clk); clr();
        bus.ev_wb_en = 1; bus.ev_wb_addr = 12; bus.ev_wb_data = 128'd1;
        bus.od_wb_en = 1; bus.od_wb_addr = 12; bus.od_wb_data = 128'd2;
        e = '0; tick(e);
        @(negedge clk); clr();
        bus.ev_in_valid = 1; bus.ev_rc_addr = 12; bus.ev_ctrl_in = 48'hC6;
        bus.od_in_valid = 1; bus.od_rt_addr = 12; bus.od_ctrl_in = 48'h6;
        e = '0; e.ev_v = 1; e.e_rc = 128'd2; e.e_ctl = 48'hC6;
        e.od_v = 1; e.o_rt = 128'd2; e.o_ctl = 48'h6; tick(e);
        // reset mid-stall clears stage and regfile
        @(negedge clk); clr(); stall = 1; reset = 1;
        e = '0; tick(e);
        @(negedge clk); reset = 0; clr();
        bus.ev_in_valid = 1; bus.ev_ra_addr = 5; bus.ev_ctrl_in = 48'hC7;
        e = '0; e.ev_v = 1; e.e_ctl = 48'hC7; tick(e);
        // r0 is an ordinary register
        @(negedge clk); clr();
        bus.ev_wb_en = 1; bus.ev_wb_addr = 0; bus.ev_wb_data = R0;
        e = '0; tick(e);
        @(negedge clk); clr();
        bus.od_in_valid = 1; bus.od_ctrl_in = 48'h8;
        e = '0; e.od_v = 1; e.o_ra = R0; e.o_rb = R0; e.o_rt = R0;
        e.o_ctl = 48'h8; tick(e);

        @(negedge clk); clr();
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (q.size() > 0) begin
            bad++;
            $display("FAIL drain got=%0d exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
